// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, taken-branch
// flush, multicycle (mul/div) sequencing and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rt,
  input  logic [4:0]  i_ex_rs,
  input  logic [4:0]  i_ex_rt,
  input  logic [4:0]  i_ex_write_reg,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_mem_write_reg,
  input  logic        i_mem_reg_write,
  input  logic [4:0]  i_wb_write_reg,
  input  logic        i_wb_reg_write,
  input  logic        i_branch_taken,
  input  logic        i_md_start,
  output logic [1:0]  o_fa,
  output logic [1:0]  o_fb,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_flush,
  output logic        o_id_flush,
  output logic        o_ex_flush,
  output logic        o_ex_hold,
  output logic        o_md_done,
  output logic        o_busy,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;
  logic        mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;

  assign load_use = i_ex_mem_read && (i_ex_write_reg != 5'd0) &&
                    ((i_ex_write_reg == i_id_rs) ||
                     ((i_ex_write_reg == i_id_rt) && i_id_uses_rt));

  assign mem_fwd_a = i_mem_reg_write && (i_mem_write_reg != 5'd0) && (i_mem_write_reg == i_ex_rs);
  assign mem_fwd_b = i_mem_reg_write && (i_mem_write_reg != 5'd0) && (i_mem_write_reg == i_ex_rt);
  assign wb_fwd_a  = i_wb_reg_write && (i_wb_write_reg != 5'd0) && (i_wb_write_reg == i_ex_rs);
  assign wb_fwd_b  = i_wb_reg_write && (i_wb_write_reg != 5'd0) && (i_wb_write_reg == i_ex_rt);

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    o_fa          = 2'b00;
    o_fb          = 2'b00;
    o_pc_write    = 1'b1;
    o_if_id_write = 1'b1;
    o_if_flush    = 1'b0;
    o_id_flush    = 1'b0;
    o_ex_flush    = 1'b0;
    o_ex_hold     = 1'b0;
    o_md_done     = 1'b0;
    o_busy        = 1'b0;

    if (!i_rst) begin
      // The younger (MEM) producer holds the newer value, so it wins.
      if (mem_fwd_a)     o_fa = 2'b10;
      else if (wb_fwd_a) o_fa = 2'b01;
      if (mem_fwd_b)     o_fb = 2'b10;
      else if (wb_fwd_b) o_fb = 2'b01;

      case (state_q)
        RUN: begin
          if (i_branch_taken) begin
            o_if_flush = 1'b1;
            o_id_flush = 1'b1;
            o_ex_flush = 1'b1;
          end else if (i_md_start) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_ex_hold     = 1'b1;
            o_ex_flush    = 1'b1;
            md_cnt_d      = MD_LOAD;
            state_d       = MD_WAIT;
          end else if (load_use) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_id_flush    = 1'b1;
          end
        end
        MD_WAIT: begin
          o_busy = 1'b1;
          if (md_cnt_q == 4'd1) begin
            o_md_done = 1'b1;
            md_cnt_d  = 4'd0;
            state_d   = RUN;
          end else begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_ex_hold     = 1'b1;
            o_ex_flush    = 1'b1;
            md_cnt_d      = md_cnt_q - 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (!o_pc_write && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4, meaning total EX-stage cycles of a multicycle (mul/div) op; legal range 2..15.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_id_rs, i_id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 i_id_uses_rt  in  1  ID instruction reads rt as an operand.
REQ-006 i_ex_rs, i_ex_rt  in  5 each  source registers of the instruction in EX.
REQ-007 i_ex_write_reg  in  5  destination of EX instruction; i_ex_mem_read  in  1  EX instruction is a load.
REQ-008 i_mem_write_reg  in  5, i_mem_reg_write  in  1  destination and write-enable of the MEM instruction.
REQ-009 i_wb_write_reg  in  5, i_wb_reg_write  in  1  destination and write-enable of the WB instruction.
REQ-010 i_branch_taken  in  1  branch in MEM resolved taken this cycle.
REQ-011 i_md_start  in  1  multicycle op present in EX this cycle (first cycle only).
REQ-012 o_fa, o_fb  out  2 each  EX operand A/B forward select: 00 register file, 01 WB data, 10 MEM data; 11 never driven.
REQ-013 o_pc_write, o_if_id_write  out  1 each  PC and IF/ID register write enables.
REQ-014 o_if_flush, o_id_flush, o_ex_flush  out  1 each  zero controls entering IF/ID, ID/EX, EX/MEM respectively.
REQ-015 o_ex_hold  out  1  hold ID/EX contents.
REQ-016 o_md_done  out  1  one-cycle pulse, multicycle result valid in EX.
REQ-017 o_busy  out  1  FSM in MD_WAIT.
REQ-018 o_stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Forwarding is combinational: o_fa=10 if i_mem_reg_write, i_mem_write_reg!=0 and ==i_ex_rs; else 01 if i_wb_reg_write, i_wb_write_reg!=0 and ==i_ex_rs; else 00; o_fb identical with i_ex_rt; MEM beats WB on double match.
REQ-020 FSM states RUN and MD_WAIT; 4-bit down-counter md_cnt.
REQ-021 Default outputs in RUN: o_pc_write=1, o_if_id_write=1, all flushes 0, o_ex_hold=0, o_md_done=0.
REQ-022 Priority in RUN: branch > multicycle start > load-use.
REQ-023 Branch (RUN, i_branch_taken=1): o_if_flush=o_id_flush=o_ex_flush=1 same cycle, o_pc_write=1; i_md_start ignored; state stays RUN.
REQ-024 Multicycle start (RUN, i_md_start=1, no branch): md_cnt<=MD_LATENCY-1, state<=MD_WAIT; that cycle o_pc_write=0, o_if_id_write=0, o_ex_hold=1, o_ex_flush=1.
REQ-025 MD_WAIT: o_pc_write=0, o_if_id_write=0, o_ex_hold=1, o_busy=1; md_cnt decrements each cycle; o_ex_flush=1 while md_cnt!=1.
REQ-026 MD_WAIT with md_cnt==1: o_ex_flush=0, o_md_done=1, o_ex_hold=0, o_pc_write=1, o_if_id_write=1; next state RUN, md_cnt<=0.
REQ-027 MD_WAIT ignores i_branch_taken, i_md_start and load-use; operands are latched by the multicycle unit on i_md_start, so forwarding changes during MD_WAIT are don't-care.
REQ-028 Load-use (RUN, no branch, no md_start): i_ex_mem_read=1, i_ex_write_reg!=0 and (==i_id_rs or (==i_id_rt and i_id_uses_rt)) -> o_pc_write=0, o_if_id_write=0, o_id_flush=1 for exactly that cycle; no state change.
REQ-029 o_stall_cnt increments by 1 on every edge where o_pc_write was 0; holds at 16'hFFFF.
REQ-030 Total PC-stall per multicycle op = MD_LATENCY-1 cycles (start cycle through md_cnt==2).

Reset
REQ-031 i_rst=1 at an edge: state<=RUN, md_cnt<=0, o_stall_cnt<=0, regardless of state, including mid-MD_WAIT.
REQ-032 While i_rst=1: o_pc_write=1, o_if_id_write=1, all flushes 0, o_ex_hold=0, o_md_done=0, o_busy=0, o_fa=o_fb=00.
REQ-033 First cycle after reset release behaves as RUN with no pending operation.

Verification
REQ-034 Forward: i_ex_rs=5, i_mem_write_reg=5/reg_write=1, i_wb_write_reg=5/reg_write=1 -> o_fa=10; MEM reg_write=0 -> 01; dest 0 -> 00.
REQ-035 Load-use: i_ex_mem_read=1, i_ex_write_reg=8, i_id_rt=8, i_id_uses_rt=1 -> one cycle pc_write=0, id_flush=1; i_id_uses_rt=0 -> no stall.
REQ-036 MD_LATENCY=4, i_md_start pulse -> pc_write=0 for 3 cycles, ex_flush=1 for 3 cycles, o_md_done pulse in 4th cycle, o_stall_cnt=3.
REQ-037 i_branch_taken=1 with i_md_start=1 and load-use same cycle -> three flushes, pc_write=1, state RUN, o_stall_cnt unchanged.
REQ-038 i_rst=1 during MD_WAIT (md_cnt=2) -> next cycle RUN, o_busy=0, o_stall_cnt=0, no o_md_done.
REQ-039 Force 65540 stall cycles -> o_stall_cnt saturates at 16'hFFFF.
